// File: rtl/activation_control_if.sv
// Activation function encoding and the instruction/datapath bundle between the
// decoder, the activation sequencer and the accumulator/activation/buffer datapath.
`timescale 1ns/1ps

package activation_control_pkg;
  typedef enum logic [3:0] {
    no_activation = 4'd0,
    relu          = 4'd1,
    relu6         = 4'd2,
    crelu         = 4'd3,
    elu           = 4'd4,
    selu          = 4'd5,
    softsign      = 4'd6,
    softplus      = 4'd7,
    sigmoid       = 4'd8,
    tanh          = 4'd9
  } activation_type;
endpackage

interface activation_control_if #(
  parameter int ACC_ADDR_WIDTH = 9,
  parameter int BUF_ADDR_WIDTH = 24,
  parameter int LENGTH_WIDTH   = 16
);
  import activation_control_pkg::*;

  logic                      instr_valid;
  logic                      instr_ready;
  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr;
  logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr;
  logic [LENGTH_WIDTH-1:0]   instr_length;
  activation_type            instr_function;
  logic                      instr_signed;

  logic                      acc_read_en;
  logic [ACC_ADDR_WIDTH-1:0] acc_read_addr;
  logic                      act_enable;
  activation_type            act_function;
  logic                      act_signed;
  logic                      buf_write_en;
  logic [BUF_ADDR_WIDTH-1:0] buf_write_addr;
  logic                      busy;
  logic                      done;

  modport master (
    output instr_valid, instr_acc_addr, instr_buf_addr, instr_length,
           instr_function, instr_signed,
    input  instr_ready, acc_read_en, acc_read_addr, act_enable, act_function,
           act_signed, buf_write_en, buf_write_addr, busy, done
  );

  modport slave (
    input  instr_valid, instr_acc_addr, instr_buf_addr, instr_length,
           instr_function, instr_signed,
    output instr_ready, acc_read_en, acc_read_addr, act_enable, act_function,
           act_signed, buf_write_en, buf_write_addr, busy, done
  );
endinterface

// File: rtl/activation_control.sv
// Activation sequencer: accepts one instruction, issues N accumulator reads and
// emits unified-buffer writes aligned with the activation pipeline output.
`timescale 1ns/1ps

module activation_control
  import activation_control_pkg::*;
#(
  parameter int MATRIX_WIDTH     = 14,
  parameter int ACC_ADDR_WIDTH   = 9,
  parameter int BUF_ADDR_WIDTH   = 24,
  parameter int LENGTH_WIDTH     = 16,
  parameter int ACC_READ_LATENCY = 2,
  parameter int ACT_LATENCY      = 3
) (
  input logic           clk,
  input logic           rst,
  activation_control_if.slave bus
);

  localparam int L = ACC_READ_LATENCY + ACT_LATENCY;

  if (L < 1 || MATRIX_WIDTH < 1) begin : g_param_check
    $error("activation_control: pipeline latency and matrix width must be positive");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [LENGTH_WIDTH-1:0]   len_q, len_d;
  logic [LENGTH_WIDTH-1:0]   read_cnt_q, read_cnt_d, read_cnt_inc;
  logic [ACC_ADDR_WIDTH-1:0] acc_read_addr_q, acc_read_addr_d;
  logic [BUF_ADDR_WIDTH-1:0] buf_write_addr_q, buf_write_addr_d;
  logic                      acc_read_en_q, acc_read_en_d;
  logic                      act_enable_q, act_enable_d;
  logic                      act_signed_q, act_signed_d;
  logic                      done_q, done_d;
  activation_type            act_function_q, act_function_d;
  logic [L-1:0]              wr_sr_q, wr_sr_d;
  logic [L-1:0]              last_sr_q, last_sr_d;
  logic                      last_issue;
  logic                      accept;

  assign accept = bus.instr_valid && (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Zero-length instructions pass through DRAIN so ready drops for the done cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (bus.instr_length == '0) ? DRAIN : ISSUE;
      ISSUE:   if (read_cnt_q == len_q) state_d = DRAIN;
      DRAIN:   if (done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d            = len_q;
    read_cnt_d       = read_cnt_q;
    read_cnt_inc     = read_cnt_q + LENGTH_WIDTH'(1);
    acc_read_addr_d  = acc_read_addr_q;
    buf_write_addr_d = buf_write_addr_q;
    act_function_d   = act_function_q;
    act_signed_d     = act_signed_q;
    act_enable_d     = act_enable_q && !done_q;
    acc_read_en_d    = 1'b0;
    last_issue       = 1'b0;
    done_d           = last_sr_q[L-1];

    if (wr_sr_q[L-1]) buf_write_addr_d = buf_write_addr_q + BUF_ADDR_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          len_d            = bus.instr_length;
          acc_read_addr_d  = bus.instr_acc_addr;
          buf_write_addr_d = bus.instr_buf_addr;
          act_function_d   = bus.instr_function;
          act_signed_d     = bus.instr_signed;
          read_cnt_d       = '0;
          if (bus.instr_length != '0) begin
            acc_read_en_d = 1'b1;
            read_cnt_d    = LENGTH_WIDTH'(1);
            last_issue    = (bus.instr_length == LENGTH_WIDTH'(1));
            act_enable_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (read_cnt_q != len_q) begin
          acc_read_en_d   = 1'b1;
          acc_read_addr_d = acc_read_addr_q + ACC_ADDR_WIDTH'(1);
          read_cnt_d      = read_cnt_inc;
          last_issue      = (read_cnt_inc == len_q);
        end
      end
      default: ;
    endcase

    // Write strobe trails the read strobe by L; the last-read marker one cycle
    // earlier so the registered done lands on the final write.
    wr_sr_d   = L'({wr_sr_q, acc_read_en_q});
    last_sr_d = L'({last_sr_q, last_issue});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q            <= '0;
      read_cnt_q       <= '0;
      acc_read_addr_q  <= '0;
      buf_write_addr_q <= '0;
      acc_read_en_q    <= 1'b0;
      act_enable_q     <= 1'b0;
      act_signed_q     <= 1'b0;
      act_function_q   <= no_activation;
      done_q           <= 1'b0;
      wr_sr_q          <= '0;
      last_sr_q        <= '0;
    end else begin
      len_q            <= len_d;
      read_cnt_q       <= read_cnt_d;
      acc_read_addr_q  <= acc_read_addr_d;
      buf_write_addr_q <= buf_write_addr_d;
      acc_read_en_q    <= acc_read_en_d;
      act_enable_q     <= act_enable_d;
      act_signed_q     <= act_signed_d;
      act_function_q   <= act_function_d;
      done_q           <= done_d;
      wr_sr_q          <= wr_sr_d;
      last_sr_q        <= last_sr_d;
    end
  end

  assign bus.instr_ready    = (state_q == IDLE);
  assign bus.busy           = (state_q != IDLE);
  assign bus.acc_read_en    = acc_read_en_q;
  assign bus.acc_read_addr  = acc_read_addr_q;
  assign bus.act_enable     = act_enable_q;
  assign bus.act_function   = act_function_q;
  assign bus.act_signed     = act_signed_q;
  assign bus.buf_write_en   = wr_sr_q[L-1];
  assign bus.buf_write_addr = buf_write_addr_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_activation_control.sv
// Self-checking bench for activation_control: directed table, hand sequences
// for hold/reset corners, and random traffic against a cycle-schedule model.
`timescale 1ns/1ps

module tb_activation_control;
  import activation_control_pkg::*;

  localparam int AW = 9;
  localparam int BW = 24;
  localparam int LW = 16;
  localparam int L  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  activation_control_if #(.ACC_ADDR_WIDTH(AW), .BUF_ADDR_WIDTH(BW), .LENGTH_WIDTH(LW)) bus ();

  activation_control #(
    .MATRIX_WIDTH(14), .ACC_ADDR_WIDTH(AW), .BUF_ADDR_WIDTH(BW), .LENGTH_WIDTH(LW),
    .ACC_READ_LATENCY(2), .ACT_LATENCY(3)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: one instruction described by its accept cycle and length; every
  // output is a function of the current cycle's offset from acceptance.
  bit          m_active = 1'b0;
  int          m_c, m_n, m_end;
  int unsigned m_acc, m_buf;
  logic [3:0]  m_fn;
  logic        m_sgn;

  int          obs_rd, obs_wr, obs_done, done_cyc;
  logic [31:0] first_raddr, last_raddr, last_waddr;

  typedef struct {
    logic [AW-1:0]  acc;
    logic [BW-1:0]  bufa;
    int             n;
    activation_type fn;
    logic           sgn;
    int             exp_done_off;
    logic [31:0]    exp_last_raddr;
    logic [31:0]    exp_last_waddr;
    int             exp_count;
  } vec_t;

  vec_t vecs[5];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic bit mready(int t);
    return !m_active || (t > m_end);
  endfunction

  task automatic clear_obs();
    obs_rd = 0; obs_wr = 0; obs_done = 0; done_cyc = -1;
    first_raddr = '0; last_raddr = '0; last_waddr = '0;
  endtask

  task automatic check_cycle();
    int t;
    bit exp_rd, exp_wr, exp_done, exp_act, in_prog;
    int unsigned off;
    t = cyc;
    if (rst) begin
      chk("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_acc_read_en", 32'(bus.acc_read_en), 32'd0);
      chk("rst_acc_read_addr", 32'(bus.acc_read_addr), 32'd0);
      chk("rst_act_enable", 32'(bus.act_enable), 32'd0);
      chk("rst_act_function", 32'(bus.act_function), 32'(no_activation));
      chk("rst_act_signed", 32'(bus.act_signed), 32'd0);
      chk("rst_buf_write_en", 32'(bus.buf_write_en), 32'd0);
      chk("rst_buf_write_addr", 32'(bus.buf_write_addr), 32'd0);
      return;
    end
    exp_rd   = m_active && t >= m_c + 1 && t <= m_c + m_n;
    exp_wr   = m_active && t >= m_c + 1 + L && t <= m_c + m_n + L;
    exp_done = m_active && t == m_end;
    exp_act  = m_active && m_n > 0 && t >= m_c + 1 && t <= m_c + m_n + L;
    in_prog  = m_active && t >= m_c + 1 && t <= m_end;
    chk("acc_read_en", 32'(bus.acc_read_en), 32'(exp_rd));
    chk("buf_write_en", 32'(bus.buf_write_en), 32'(exp_wr));
    chk("done", 32'(bus.done), 32'(exp_done));
    chk("act_enable", 32'(bus.act_enable), 32'(exp_act));
    if (!(m_active && m_n == 0 && t == m_c + 1)) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(!in_prog));
      chk("busy", 32'(bus.busy), 32'(in_prog));
    end
    if (exp_rd) begin
      off = unsigned'(t - m_c - 1);
      chk("acc_read_addr", 32'(bus.acc_read_addr), (m_acc + off) & 32'h1FF);
    end
    if (exp_wr) begin
      off = unsigned'(t - m_c - 1 - L);
      chk("buf_write_addr", 32'(bus.buf_write_addr), (m_buf + off) & 32'hFF_FFFF);
    end
    if (exp_act) begin
      chk("act_function", 32'(bus.act_function), 32'(m_fn));
      chk("act_signed", 32'(bus.act_signed), 32'(m_sgn));
    end
    if (bus.acc_read_en) begin
      if (obs_rd == 0) first_raddr = 32'(bus.acc_read_addr);
      last_raddr = 32'(bus.acc_read_addr);
      obs_rd++;
    end
    if (bus.buf_write_en) begin
      last_waddr = 32'(bus.buf_write_addr);
      obs_wr++;
    end
    if (bus.done) begin
      obs_done++;
      done_cyc = t;
    end
  endtask

  task automatic tick();
    check_cycle();
    @(posedge clk);
    if (!rst && mready(cyc) && bus.instr_valid) begin
      m_active = 1'b1;
      m_c      = cyc;
      m_n      = int'(bus.instr_length);
      m_acc    = 32'(bus.instr_acc_addr);
      m_buf    = 32'(bus.instr_buf_addr);
      m_fn     = bus.instr_function;
      m_sgn    = bus.instr_signed;
      m_end    = (m_n == 0) ? cyc + 1 : cyc + m_n + L;
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] acc, input logic [BW-1:0] bufa,
                       input int n, input activation_type fn, input logic sgn);
    bus.instr_valid    = v;
    bus.instr_acc_addr = acc;
    bus.instr_buf_addr = bufa;
    bus.instr_length   = LW'(n);
    bus.instr_function = fn;
    bus.instr_signed   = sgn;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!mready(cyc) && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (obs_done == 0 && k < bound) begin
      tick();
      k++;
    end
    chk("done_seen_within_bound", 32'(obs_done != 0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_c, found;

    vecs[0] = '{9'd10,  24'd100,      4,     relu,    1'b1, 9,     32'd13,  32'd103,     4};
    vecs[1] = '{9'd510, 24'hFFFFFE,   4,     elu,     1'b0, 9,     32'd1,   32'd1,       4};
    vecs[2] = '{9'd7,   24'd5,        0,     tanh,    1'b1, 1,     32'd0,   32'd0,       0};
    vecs[3] = '{9'd3,   24'd50,       1,     sigmoid, 1'b0, 6,     32'd3,   32'd50,      1};
    vecs[4] = '{9'd0,   24'hFFFF00,   65535, relu6,   1'b1, 65540, 32'd510, 32'h00FEFE,  65535};

    rst = 1'b1;
    drive(1'b0, '0, '0, 0, no_activation, 1'b0);
    clear_obs();
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      wait_ready();
      clear_obs();
      drive(1'b1, vecs[i].acc, vecs[i].bufa, vecs[i].n, vecs[i].fn, vecs[i].sgn);
      a_c = cyc;
      tick();
      bus.instr_valid = 1'b0;
      wait_done(vecs[i].n + L + 10);
      chk("done_offset", 32'(done_cyc - a_c), 32'(vecs[i].exp_done_off));
      chk("read_count", 32'(obs_rd), 32'(vecs[i].exp_count));
      chk("write_count", 32'(obs_wr), 32'(vecs[i].exp_count));
      if (vecs[i].exp_count > 0) begin
        chk("first_read_addr", first_raddr, 32'(vecs[i].acc));
        chk("last_read_addr", last_raddr, vecs[i].exp_last_raddr);
        chk("last_write_addr", last_waddr, vecs[i].exp_last_waddr);
      end
    end

    // Instruction held valid while busy: ignored until ready, then taken.
    wait_ready();
    clear_obs();
    drive(1'b1, 9'd20, 24'd200, 3, crelu, 1'b1);
    a_c = cyc;
    tick();
    drive(1'b1, 9'd300, 24'h123456, 2, softplus, 1'b1);
    found = -1;
    for (int k = 0; k < 30 && found < 0; k++) begin
      if (bus.acc_read_en && bus.acc_read_addr == 9'd300) found = cyc;
      tick();
    end
    chk("held_instr_first_read_offset", 32'(found - a_c), 32'(3 + L + 2));
    bus.instr_valid = 1'b0;
    clear_obs();
    wait_done(20);

    // Reset after two reads of an 8-row instruction.
    wait_ready();
    drive(1'b1, 9'd40, 24'd400, 8, selu, 1'b0);
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    m_active = 1'b0;
    #1;
    tick();
    rst = 1'b0;
    clear_obs();
    for (int k = 0; k < 15; k++) tick();
    chk("post_reset_writes", 32'(obs_wr), 32'd0);
    chk("post_reset_done", 32'(obs_done), 32'd0);
    chk("post_reset_ready", 32'(bus.instr_ready), 32'd1);

    // Random traffic; valid toggles freely, including while busy.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom), BW'($urandom), int'($urandom_range(0, 12)),
            activation_type'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      tick();
    end
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 30; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
